icache_dm2w: RTL and testbench
==============================

Name: icache_dm2w

Overview:
- Direct-mapped instruction cache between the pipeline's instruction fetch port (imemREN/imemaddr -> ihit/imemload) and the memory controller's instruction port (iREN/iaddr <- iload/iwait).
- Each block holds 2 words. A miss fetches both words of the aligned block, then installs the frame.
- ihit is the stall/advance qualifier used by the PC and pipeline-register enables.

Parameters:
- SETS, 8, number of frames; power of 2; index width IDXW = log2(SETS).
- WORDS, 2, words per block; fixed at 2 (block-offset width 1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- imemREN  in  1  fetch request from the datapath.
- imemaddr  in  32  fetch byte address; word-aligned.
- flush  in  1  invalidate all frames.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word; 0 when ihit=0.
- iREN  out  1  read request to the memory controller.
- iaddr  out  32  word address to the memory controller.
- iload  in  32  read data from the memory controller.
- iwait  in  1  memory busy; data is valid in the cycle iwait=0.
- hit_count  out  32  number of hit cycles.
- miss_count  out  32  number of misses.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Address split:
  - tag = imemaddr[31:3+IDXW]
  - idx = imemaddr[2+IDXW:3]
  - blkoff = imemaddr[2]
  - [1:0] ignored
- Storage per frame: valid, tag, data[0..1].
- FSM states: IDLE, FETCH0, FETCH1.
- ihit = (state==IDLE) & imemREN & valid[idx] & (tag match) & !flush. Combinational, same cycle as the request.
- imemload = data[idx][blkoff] when ihit, else 32'h0.
- IDLE:
  - If imemREN & !hit & !flush: latch miss_tag and miss_idx, increment miss_count, go to FETCH0.
  - iREN=0, iaddr=0.
- FETCH0:
  - iREN=1, iaddr = {miss_tag, miss_idx, 1'b0, 2'b00}.
  - When iwait=0: capture iload into buf0, go to FETCH1.
  - Else stay in FETCH0.
- FETCH1:
  - iREN=1, iaddr = {miss_tag, miss_idx, 1'b1, 2'b00}.
  - When iwait=0: write frame[miss_idx] with tag=miss_tag, data0=buf0, data1=iload, valid=1; go to IDLE.
- Miss latency: with iwait=0 throughout, a request that misses in cycle N hits in cycle N+3.
- Fill is not aborted when imemREN drops or imemaddr changes mid-fill. The latched block is still installed. The new address is looked up back in IDLE.
- A fill always overwrites (evicts) the indexed frame, valid or not.
- Flush:
  - Clears every valid bit at the next edge, in any state.
  - In FETCH0/FETCH1, flush aborts the fill: no frame is written, state goes to IDLE next cycle, and iREN is low from that cycle.
  - ihit=0 in any cycle where flush=1.
- Counters:
  - hit_count +1 on each cycle with ihit=1.
  - miss_count +1 on each IDLE->FETCH0 transition.
  - Both saturate at 32'hFFFFFFFF.
  - Flush does not clear the counters.
- Reset (RST=1 at an edge): state=IDLE, all valid=0, counters=0, buf0=0. Outputs ihit=0, imemload=0, iREN=0, iaddr=0.
- Reset asserted mid-fill abandons the fill with no frame written.
- Reset has priority over flush; flush has priority over fill completion.
- Tags and data need no reset.

Test Plan:
- Cold miss, then hit:
  - Stimulus: after reset, imemREN=1, imemaddr=0x40, iwait=0, memory returns 0xAAAA0000 at 0x40 and 0xBBBB0000 at 0x44.
  - Required: iaddr=0x40 then 0x44; ihit=1 with imemload=0xAAAA0000 3 cycles after the request; miss_count=1.
  - Then imemaddr=0x44 -> same-cycle hit, imemload=0xBBBB0000, no iREN.
- Wait states:
  - Stimulus: iwait=1 for 4 cycles in FETCH0 and 2 cycles in FETCH1.
  - Required: iaddr holds its value while iwait=1; hit arrives 9 cycles after the request.
- Conflict eviction (SETS=8):
  - Stimulus: fill 0x000, then request 0x040 (same idx 0, different tag), then 0x000 again.
  - Required: three misses; miss_count=3; imemload correct each time.
- Address change mid-fill:
  - Stimulus: miss on 0x80; in FETCH1 switch imemaddr to 0x84.
  - Required: block 0x80 installed; 0x84 hits immediately on return to IDLE.
- Flush:
  - Stimulus A: after filling 0x40, pulse flush=1.
  - Required A: next request to 0x40 misses.
  - Stimulus B: flush during FETCH0.
  - Required B: iREN=0 the next cycle; no frame written; a request to the same address misses again.
- Synchronous reset mid-fill:
  - Stimulus: RST=1 for 1 cycle during FETCH1.
  - Required: next cycle state=IDLE, iREN=0, hit_count=0, miss_count=0, all lookups miss.

Source files
------------

// File: rtl/icache_dm2w.sv
// Direct-mapped instruction cache with 2-word blocks between the fetch port and the
// memory controller's instruction port. Misses fetch both words, then install the frame.
module icache_dm2w #(
    parameter int unsigned SETS  = 8,
    parameter int unsigned WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned OFFW = $clog2(WORDS);
    localparam int unsigned TAGW = 32 - 2 - OFFW - IDXW;

    typedef enum logic [1:0] {StIdle, StFetch0, StFetch1} state_e;

    state_e state_q, state_d;

    logic [SETS-1:0] valid_q;
    logic [TAGW-1:0] tag_q   [SETS];
    logic [31:0]     data0_q [SETS];
    logic [31:0]     data1_q [SETS];

    logic [31:0]     buf0_q;
    logic [TAGW-1:0] miss_tag_q;
    logic [IDXW-1:0] miss_idx_q;

    logic [TAGW-1:0] req_tag;
    logic [IDXW-1:0] req_idx;
    logic            req_off;
    logic            lookup_hit;
    logic            start_miss;
    logic            cap_buf;
    logic            fill;
    logic            unused_addr;

    assign req_tag     = imemaddr[31 -: TAGW];
    assign req_idx     = imemaddr[2+OFFW +: IDXW];
    assign req_off     = imemaddr[2];
    assign unused_addr = ^imemaddr[1:0];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ihit       = (state_q == StIdle) && imemREN && lookup_hit && !flush;
    assign imemload   = ihit ? (req_off ? data1_q[req_idx] : data0_q[req_idx]) : 32'h0;

    always_comb begin
        state_d    = state_q;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        start_miss = 1'b0;
        cap_buf    = 1'b0;
        fill       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (imemREN && !lookup_hit && !flush) begin
                    start_miss = 1'b1;
                    state_d    = StFetch0;
                end
            end
            StFetch0: begin
                iREN  = 1'b1;
                iaddr = {miss_tag_q, miss_idx_q, 1'b0, 2'b00};
                // Flush wins over a beat completing in the same cycle.
                if (flush) begin
                    state_d = StIdle;
                end else if (!iwait) begin
                    cap_buf = 1'b1;
                    state_d = StFetch1;
                end
            end
            StFetch1: begin
                iREN  = 1'b1;
                iaddr = {miss_tag_q, miss_idx_q, 1'b1, 2'b00};
                if (flush) begin
                    state_d = StIdle;
                end else if (!iwait) begin
                    fill    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            buf0_q     <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[miss_idx_q] <= 1'b1;
            end
            if (cap_buf) begin
                buf0_q <= iload;
            end
            if (start_miss) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
            end
            if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

    // Tag/data arrays carry no reset; validity alone governs hits.
    always_ff @(posedge CLK) begin
        if (fill && !RST) begin
            tag_q[miss_idx_q]   <= miss_tag_q;
            data0_q[miss_idx_q] <= buf0_q;
            data1_q[miss_idx_q] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_dm2w.sv
// Bench for icache_dm2w: block-level reference model checked every cycle, plus directed
// scenarios with hand-computed cycle-exact expectations.
module tb_icache_dm2w;

    localparam int unsigned SETS = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        flush = 1'b0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    icache_dm2w #(.SETS(SETS), .WORDS(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .flush     (flush),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iload     (iload),
        .iwait     (iwait),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hAAAA_0000;
        if (a == 32'h44) return 32'hBBBB_0000;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory responder: programmable wait states per beat (w0 for word 0, w1 for word 1).
    int unsigned w0 = 0;
    int unsigned w1 = 0;
    int unsigned beat_cnt = 0;
    assign iload = mem_word(iaddr);
    assign iwait = iREN && (beat_cnt < (iaddr[2] ? w1 : w0));
    always @(posedge CLK) begin
        if (iREN && iwait) beat_cnt <= beat_cnt + 1;
        else               beat_cnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frames hold a block base address; pending fill is a queue of beats.
    logic        m_valid [SETS];
    logic [31:0] m_base  [SETS];
    logic [31:0] m_word  [SETS][2];
    logic [31:0] m_q[$];
    logic [31:0] m_buf;
    logic [31:0] m_fill_base;
    logic [31:0] m_hits = 0;
    logic [31:0] m_misses = 0;

    initial begin
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            begin
                int unsigned idx;
                int unsigned fidx;
                logic [31:0] base;
                logic        busy;
                logic        hitl;
                logic        e_ihit;
                logic [31:0] e_load;
                base   = imemaddr & ~32'h7;
                idx    = (imemaddr >> 3) % SETS;
                busy   = (m_q.size() != 0);
                hitl   = m_valid[idx] && (m_base[idx] == base);
                e_ihit = !busy && imemREN && !flush && hitl;
                e_load = e_ihit ? m_word[idx][imemaddr[2]] : 32'h0;
                chk("m_ihit", 32'(ihit), 32'(e_ihit));
                chk("m_imemload", imemload, e_load);
                chk("m_iREN", 32'(iREN), 32'(busy));
                chk("m_iaddr", iaddr, busy ? m_q[0] : 32'h0);
                chk("m_hit_count", hit_count, m_hits);
                chk("m_miss_count", miss_count, m_misses);
                if (RST) begin
                    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
                    m_q.delete();
                    m_hits   = 0;
                    m_misses = 0;
                end else begin
                    if (e_ihit && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
                    if (flush) begin
                        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
                        m_q.delete();
                    end else if (busy) begin
                        if (!iwait) begin
                            if (m_q.size() == 2) begin
                                m_buf = mem_word(m_q[0]);
                            end else begin
                                fidx = (m_fill_base >> 3) % SETS;
                                m_valid[fidx]   = 1'b1;
                                m_base[fidx]    = m_fill_base;
                                m_word[fidx][0] = m_buf;
                                m_word[fidx][1] = mem_word(m_q[0]);
                            end
                            void'(m_q.pop_front());
                        end
                    end else if (imemREN && !hitl) begin
                        m_fill_base = base;
                        m_q.push_back(base);
                        m_q.push_back(base + 32'h4);
                        if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        imemREN = 1'b0;
        flush = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    // Issue a request and hold it until it hits; check hit latency and returned word.
    task automatic do_req(input logic [31:0] a, input int exp_lat, input string nm);
        int lat;
        lat = 0;
        imemREN = 1'b1;
        imemaddr = a;
        @(negedge CLK);
        while (!ihit && lat < 30) begin
            tick();
            @(negedge CLK);
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_data"}, imemload, mem_word(a));
        tick();
        imemREN = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_ihit", 32'(ihit), 0);
        chk("rst_imemload", imemload, 0);
        chk("rst_iREN", 32'(iREN), 0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);

        // Cold miss then hit on both words
        tick();
        imemREN = 1'b1;
        imemaddr = 32'h40;
        @(negedge CLK);
        chk("cold_n0_ihit", 32'(ihit), 0);
        tick(); @(negedge CLK);
        chk("cold_n1_iREN", 32'(iREN), 1);
        chk("cold_n1_iaddr", iaddr, 32'h40);
        tick(); @(negedge CLK);
        chk("cold_n2_iaddr", iaddr, 32'h44);
        tick(); @(negedge CLK);
        chk("cold_n3_ihit", 32'(ihit), 1);
        chk("cold_n3_load", imemload, 32'hAAAA_0000);
        chk("cold_miss_count", miss_count, 1);
        tick();
        imemaddr = 32'h44;
        @(negedge CLK);
        chk("word1_ihit", 32'(ihit), 1);
        chk("word1_load", imemload, 32'hBBBB_0000);
        chk("word1_iREN", 32'(iREN), 0);
        tick();
        imemREN = 1'b0;
        @(negedge CLK);
        chk("cold_hit_count", hit_count, 2);
        tick();

        // Wait states: 4 in FETCH0, 2 in FETCH1; hit 9 cycles after request
        w0 = 4;
        w1 = 2;
        imemREN = 1'b1;
        imemaddr = 32'h100;
        for (int k = 1; k <= 9; k++) begin
            tick();
            @(negedge CLK);
            if (k <= 5) chk("wait_iaddr0", iaddr, 32'h100);
            else if (k <= 8) chk("wait_iaddr1", iaddr, 32'h104);
            else begin
                chk("wait_hit_n9", 32'(ihit), 1);
                chk("wait_load", imemload, 32'hC0DE_0100);
            end
        end
        tick();
        imemREN = 1'b0;
        w0 = 0;
        w1 = 0;

        // Conflict eviction on index 0
        do_reset();
        do_req(32'h000, 3, "conf_a");
        do_req(32'h040, 3, "conf_b");
        do_req(32'h000, 3, "conf_c");
        @(negedge CLK);
        chk("conf_miss_count", miss_count, 3);
        tick();

        // Address change mid-fill: block 0x80 still installed
        imemREN = 1'b1;
        imemaddr = 32'h80;
        tick();
        tick();
        imemaddr = 32'h84;
        tick();
        @(negedge CLK);
        chk("mid_ihit", 32'(ihit), 1);
        chk("mid_load", imemload, 32'hC0DE_0084);
        tick();
        imemREN = 1'b0;
        do_req(32'h80, 0, "mid_blk0");

        // Flush A: invalidates installed block; no hit while flush is high
        do_req(32'h40, 3, "flA_fill");
        imemREN = 1'b1;
        imemaddr = 32'h40;
        flush = 1'b1;
        @(negedge CLK);
        chk("flA_ihit", 32'(ihit), 0);
        chk("flA_load", imemload, 0);
        tick();
        flush = 1'b0;
        do_req(32'h40, 3, "flA_miss");

        // Flush B: abort during FETCH0
        imemREN = 1'b1;
        imemaddr = 32'h200;
        tick();
        flush = 1'b1;
        imemREN = 1'b0;
        tick();
        flush = 1'b0;
        @(negedge CLK);
        chk("flB_iREN", 32'(iREN), 0);
        chk("flB_iaddr", iaddr, 0);
        tick();
        do_req(32'h200, 3, "flB_miss");
        @(negedge CLK);
        chk("flB_miss_count", miss_count, 8);
        tick();

        // Synchronous reset during FETCH1
        imemREN = 1'b1;
        imemaddr = 32'h300;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        imemREN = 1'b0;
        @(negedge CLK);
        chk("rstf_iREN", 32'(iREN), 0);
        chk("rstf_hit_count", hit_count, 0);
        chk("rstf_miss_count", miss_count, 0);
        tick();
        do_req(32'h200, 3, "rstf_old");
        do_req(32'h304, 3, "rstf_blk");

        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
